// File: rtl/ptw_mem_responder.sv
// rtl/ptw_mem_responder.sv - PTE read / A-D mark responder for the page-table walker (optional line buffer: PTW_LINE_BUF_EN)
module ptw_mem_responder #(
    parameter int PA_WIDTH = 32,
    parameter int A_BIT    = 6,
    parameter int D_BIT    = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                walk_req_valid,
    input  logic [PA_WIDTH-1:0] walk_req_addr,
    output logic                walk_rsp_valid,
    output logic [63:0]         walk_rsp_data,
    output logic [127:0]        walk_rsp_cacheline,
    input  logic                mark_valid,
    input  logic                mark_accessed,
    input  logic                mark_dirty,
    input  logic [63:0]         mark_addr,
    output logic                mark_rsp_valid,
    output logic                mem_valid,
    output logic [PA_WIDTH-1:0] mem_addr,
    output logic                mem_store,
    output logic [127:0]        mem_wdata,
    input  logic                mem_ack,
    input  logic [127:0]        mem_rdata,
    output logic                proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        MK_ISSUE,
        MK_WAIT,
        MK_MODIFY,
        WR_ISSUE,
        WR_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [PA_WIDTH-1:0] addr_q, addr_d;
    logic                acc_q, acc_d;
    logic                dirty_q, dirty_d;
    logic [127:0]        line_q, line_d;

    // Mark request parked behind a walk (or arriving while busy)
    logic                pend_q, pend_d;
    logic [PA_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                pend_acc_q, pend_acc_d;
    logic                pend_dirty_q, pend_dirty_d;

    logic                walk_rsp_valid_q, walk_rsp_valid_d;
    logic [63:0]         walk_rsp_data_q, walk_rsp_data_d;
    logic [127:0]        walk_rsp_line_q, walk_rsp_line_d;
    logic                mark_rsp_valid_q, mark_rsp_valid_d;
    logic                proto_err_q, proto_err_d;

    logic [63:0]         old_dword;
    logic [63:0]         set_mask;
    logic [63:0]         new_dword;
    logic [127:0]        mod_line;
    logic                rd_hit;
    logic                in_mem_state;

`ifdef PTW_LINE_BUF_EN
    logic                buf_valid_q, buf_valid_d;
    logic [PA_WIDTH-5:0] buf_tag_q, buf_tag_d;
    logic [127:0]        buf_line_q, buf_line_d;

    assign rd_hit = (state_q == RD_ISSUE) && buf_valid_q
                    && (buf_tag_q == addr_q[PA_WIDTH-1:4]);
`else
    assign rd_hit = 1'b0;
`endif

    // Read-modify-write of the selected PTE dword; A is implied by D
    assign old_dword = addr_q[3] ? line_q[127:64] : line_q[63:0];
    assign set_mask  = (64'(acc_q | dirty_q) << A_BIT) | (64'(dirty_q) << D_BIT);
    assign new_dword = old_dword | set_mask;
    assign mod_line  = addr_q[3] ? {new_dword, line_q[63:0]} : {line_q[127:64], new_dword};

    assign in_mem_state = (state_q == RD_ISSUE) || (state_q == RD_WAIT)
                       || (state_q == MK_ISSUE) || (state_q == MK_WAIT)
                       || (state_q == WR_ISSUE) || (state_q == WR_WAIT);

    assign mem_valid          = in_mem_state && !rd_hit;
    assign mem_store          = (state_q == WR_ISSUE) || (state_q == WR_WAIT);
    assign mem_addr           = {addr_q[PA_WIDTH-1:4], 4'b0000};
    assign mem_wdata          = line_q;
    assign walk_rsp_valid     = walk_rsp_valid_q;
    assign walk_rsp_data      = walk_rsp_data_q;
    assign walk_rsp_cacheline = walk_rsp_line_q;
    assign mark_rsp_valid     = mark_rsp_valid_q;
    assign proto_err          = proto_err_q;

    // Byte offset within the dword and upper mark address bits are don't-care
    logic unused_bits;
    assign unused_bits = ^{mark_addr[63:PA_WIDTH], addr_q[2:0]};

    // Next-state, request capture, response and mark bookkeeping
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        acc_d            = acc_q;
        dirty_d          = dirty_q;
        line_d           = line_q;
        pend_d           = pend_q;
        pend_addr_d      = pend_addr_q;
        pend_acc_d       = pend_acc_q;
        pend_dirty_d     = pend_dirty_q;
        walk_rsp_valid_d = 1'b0;
        walk_rsp_data_d  = walk_rsp_data_q;
        walk_rsp_line_d  = walk_rsp_line_q;
        mark_rsp_valid_d = 1'b0;
        proto_err_d      = proto_err_q;
`ifdef PTW_LINE_BUF_EN
        buf_valid_d      = buf_valid_q;
        buf_tag_d        = buf_tag_q;
        buf_line_d       = buf_line_q;
`endif

        if (state_q == IDLE) begin
            if (walk_req_valid) begin
                addr_d  = walk_req_addr;
                state_d = RD_ISSUE;
                if (mark_valid) begin
                    if (pend_q) begin
                        proto_err_d = 1'b1;
                    end else begin
                        pend_d       = 1'b1;
                        pend_addr_d  = mark_addr[PA_WIDTH-1:0];
                        pend_acc_d   = mark_accessed;
                        pend_dirty_d = mark_dirty;
                    end
                end
            end else if (pend_q) begin
                addr_d  = pend_addr_q;
                acc_d   = pend_acc_q;
                dirty_d = pend_dirty_q;
                pend_d  = 1'b0;
                state_d = MK_ISSUE;
                if (mark_valid) begin
                    pend_d       = 1'b1;
                    pend_addr_d  = mark_addr[PA_WIDTH-1:0];
                    pend_acc_d   = mark_accessed;
                    pend_dirty_d = mark_dirty;
                end
            end else if (mark_valid) begin
                addr_d  = mark_addr[PA_WIDTH-1:0];
                acc_d   = mark_accessed;
                dirty_d = mark_dirty;
                state_d = MK_ISSUE;
            end
        end else begin
            if (walk_req_valid) begin
                proto_err_d = 1'b1;
            end
            if (mark_valid) begin
                if (pend_q) begin
                    proto_err_d = 1'b1;
                end else begin
                    pend_d       = 1'b1;
                    pend_addr_d  = mark_addr[PA_WIDTH-1:0];
                    pend_acc_d   = mark_accessed;
                    pend_dirty_d = mark_dirty;
                end
            end
        end

        case (state_q)
            RD_ISSUE, RD_WAIT: begin
`ifdef PTW_LINE_BUF_EN
                if (rd_hit) begin
                    walk_rsp_valid_d = 1'b1;
                    walk_rsp_line_d  = buf_line_q;
                    walk_rsp_data_d  = addr_q[3] ? buf_line_q[127:64] : buf_line_q[63:0];
                    state_d          = IDLE;
                end else
`endif
                if (mem_ack) begin
                    walk_rsp_valid_d = 1'b1;
                    walk_rsp_line_d  = mem_rdata;
                    walk_rsp_data_d  = addr_q[3] ? mem_rdata[127:64] : mem_rdata[63:0];
                    state_d          = IDLE;
`ifdef PTW_LINE_BUF_EN
                    buf_valid_d      = 1'b1;
                    buf_tag_d        = addr_q[PA_WIDTH-1:4];
                    buf_line_d       = mem_rdata;
`endif
                end else begin
                    state_d = RD_WAIT;
                end
            end
            MK_ISSUE, MK_WAIT: begin
                if (mem_ack) begin
                    line_d  = mem_rdata;
                    state_d = MK_MODIFY;
                end else begin
                    state_d = MK_WAIT;
                end
            end
            MK_MODIFY: begin
                if (new_dword == old_dword) begin
                    mark_rsp_valid_d = 1'b1;
                    state_d          = IDLE;
                end else begin
                    line_d  = mod_line;
                    state_d = WR_ISSUE;
                end
            end
            WR_ISSUE, WR_WAIT: begin
                if (mem_ack) begin
                    mark_rsp_valid_d = 1'b1;
                    state_d          = IDLE;
`ifdef PTW_LINE_BUF_EN
                    if (buf_valid_q && (buf_tag_q == addr_q[PA_WIDTH-1:4])) begin
                        buf_line_d = line_q;
                    end
`endif
                end else begin
                    state_d = WR_WAIT;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            acc_q            <= 1'b0;
            dirty_q          <= 1'b0;
            line_q           <= '0;
            pend_q           <= 1'b0;
            pend_addr_q      <= '0;
            pend_acc_q       <= 1'b0;
            pend_dirty_q     <= 1'b0;
            walk_rsp_valid_q <= 1'b0;
            walk_rsp_data_q  <= '0;
            walk_rsp_line_q  <= '0;
            mark_rsp_valid_q <= 1'b0;
            proto_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            acc_q            <= acc_d;
            dirty_q          <= dirty_d;
            line_q           <= line_d;
            pend_q           <= pend_d;
            pend_addr_q      <= pend_addr_d;
            pend_acc_q       <= pend_acc_d;
            pend_dirty_q     <= pend_dirty_d;
            walk_rsp_valid_q <= walk_rsp_valid_d;
            walk_rsp_data_q  <= walk_rsp_data_d;
            walk_rsp_line_q  <= walk_rsp_line_d;
            mark_rsp_valid_q <= mark_rsp_valid_d;
            proto_err_q      <= proto_err_d;
        end
    end

`ifdef PTW_LINE_BUF_EN
    // One-entry line buffer, invalidated by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_line_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_line_q  <= buf_line_d;
        end
    end
`endif

endmodule

// File: tb/tb_ptw_mem_responder.sv
// tb/tb_ptw_mem_responder.sv - self-checking bench for ptw_mem_responder
module tb_ptw_mem_responder;

    localparam int PA = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          walk_req_valid;
    logic [PA-1:0] walk_req_addr;
    logic          walk_rsp_valid;
    logic [63:0]   walk_rsp_data;
    logic [127:0]  walk_rsp_cacheline;
    logic          mark_valid;
    logic          mark_accessed;
    logic          mark_dirty;
    logic [63:0]   mark_addr;
    logic          mark_rsp_valid;
    logic          mem_valid;
    logic [PA-1:0] mem_addr;
    logic          mem_store;
    logic [127:0]  mem_wdata;
    logic          mem_ack;
    logic [127:0]  mem_rdata;
    logic          proto_err;

    ptw_mem_responder #(.PA_WIDTH(PA), .A_BIT(6), .D_BIT(7)) dut (
        .clk(clk), .reset(reset),
        .walk_req_valid(walk_req_valid), .walk_req_addr(walk_req_addr),
        .walk_rsp_valid(walk_rsp_valid), .walk_rsp_data(walk_rsp_data),
        .walk_rsp_cacheline(walk_rsp_cacheline),
        .mark_valid(mark_valid), .mark_accessed(mark_accessed),
        .mark_dirty(mark_dirty), .mark_addr(mark_addr),
        .mark_rsp_valid(mark_rsp_valid),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_store(mem_store),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0]  data;
        logic [127:0] line;
    } exp_t;
    exp_t exp_q[$];

    logic [127:0] mem_arr [0:4095];
    int mem_lat = 1;
    int mcnt = 0;
    int acks = 0;
    int stores = 0;
    int mv_cycles = 0;
    int walk_cnt = 0;
    int walk_cyc = 0;
    int mark_cnt = 0;
    int mark_cyc = 0;

    always @(posedge clk) cyc++;

    // Backing memory: acks after mem_lat extra presented cycles
    always @(posedge clk) begin
        #1;
        if (mem_valid) mv_cycles++;
        if (reset) begin
            mem_ack = 1'b0;
            mcnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            mcnt = 0;
        end else if (mem_valid) begin
            if (mcnt >= mem_lat) begin
                mem_ack = 1'b1;
                acks++;
                mem_rdata = mem_arr[mem_addr[15:4]];
                if (mem_store) begin
                    mem_arr[mem_addr[15:4]] = mem_wdata;
                    stores++;
                end
            end else begin
                mcnt++;
            end
        end else begin
            mcnt = 0;
        end
    end

    // Response monitor: walk responses are scored against the queue
    always @(posedge clk) begin
        #2;
        if (walk_rsp_valid) begin
            exp_t e;
            walk_cnt++;
            walk_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL walk_rsp_unexpected: got data %h, expected no response", walk_rsp_data);
            end else begin
                e = exp_q.pop_front();
                if (walk_rsp_data !== e.data || walk_rsp_cacheline !== e.line) begin
                    n_fail++;
                    $display("FAIL walk_rsp_data: got %h/%h, expected %h/%h",
                             walk_rsp_data, walk_rsp_cacheline, e.data, e.line);
                end
            end
        end
        if (mark_rsp_valid) begin
            mark_cnt++;
            mark_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Issue a walk read, queue its expected response, wait; lat = -1 on timeout
    task automatic do_walk(input logic [PA-1:0] addr, output int lat);
        exp_t e;
        int start, rc;
        e.line = mem_arr[addr[15:4]];
        e.data = addr[3] ? e.line[127:64] : e.line[63:0];
        exp_q.push_back(e);
        @(negedge clk);
        walk_req_valid = 1'b1;
        walk_req_addr = addr;
        rc = cyc;
        start = walk_cnt;
        @(negedge clk);
        walk_req_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (walk_cnt > start) begin
                lat = walk_cyc - rc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Issue a mark, wait for completion; lat = -1 on timeout
    task automatic do_mark(input logic [PA-1:0] addr, input logic acc, input logic dirty, output int lat);
        int start, rc;
        @(negedge clk);
        mark_valid = 1'b1;
        mark_addr = 64'(addr);
        mark_accessed = acc;
        mark_dirty = dirty;
        rc = cyc;
        start = mark_cnt;
        @(negedge clk);
        mark_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (mark_cnt > start) begin
                lat = mark_cyc - rc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        walk_req_valid = 1'b0;
        walk_req_addr = '0;
        mark_valid = 1'b0;
        mark_accessed = 1'b0;
        mark_dirty = 1'b0;
        mark_addr = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_valid !== 1'b0 || mem_store !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem: got valid %b store %b, expected 0 0", mem_valid, mem_store);
        end
        n_checks++;
        if (walk_rsp_valid !== 1'b0 || mark_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp: got %b %b, expected 0 0", walk_rsp_valid, mark_rsp_valid);
        end
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_proto_err: got %b, expected 0", proto_err);
        end
        n_checks++;
        if (walk_rsp_data !== 64'h0 || mem_addr !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h, expected 0 0", walk_rsp_data, mem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        int lat, a0, start, rc;
        exp_t e;
        mem_lat = 1;
        mem_arr[12'h100] = {64'h0000_0000_AAAA_0001, 64'h0000_0000_5555_0001};
        e.line = {64'h0000_0000_AAAA_0001, 64'h0000_0000_5555_0001};
        e.data = 64'h0000_0000_AAAA_0001;
        exp_q.push_back(e);
        a0 = acks;
        @(negedge clk);
        walk_req_valid = 1'b1;
        walk_req_addr = 32'h1008;
        rc = cyc;
        start = walk_cnt;
        @(negedge clk);
        walk_req_valid = 1'b0;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 || mem_store !== 1'b0) begin
            n_fail++; $display("FAIL read_issue: got valid %b addr %h store %b, expected 1 00001000 0",
                               mem_valid, mem_addr, mem_store);
        end
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (walk_cnt > start) begin lat = walk_cyc - rc; break; end
            @(negedge clk);
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++; $display("FAIL read_latency: got %0d, expected 3", lat);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (acks - a0 != 1 || walk_rsp_data !== 64'h0000_0000_AAAA_0001) begin
            n_fail++; $display("FAIL read_hold: got acks %0d data %h, expected 1 00000000aaaa0001", acks - a0, walk_rsp_data);
        end
        mem_arr[12'h110] = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        do_walk(32'h1104, lat);
        n_checks++;
        if (lat != 3) begin
            n_fail++; $display("FAIL read_misaligned_latency: got %0d, expected 3", lat);
        end
    endtask

    task automatic test_mark_a();
        int lat, s0;
        mem_lat = 1;
        mem_arr[12'h200] = {64'h0000_0000_0000_1234, 64'h0000_0000_0000_000F};
        s0 = stores;
        do_mark(32'h2000, 1'b1, 1'b0, lat);
        n_checks++;
        if (lat != 6) begin
            n_fail++; $display("FAIL mark_a_latency: got %0d, expected 6", lat);
        end
        n_checks++;
        if (stores - s0 != 1 || mem_arr[12'h200] !== {64'h0000_0000_0000_1234, 64'h0000_0000_0000_004F}) begin
            n_fail++; $display("FAIL mark_a_write: got stores %0d line %h, expected 1 line with lo 4f",
                               stores - s0, mem_arr[12'h200]);
        end
    endtask

    task automatic test_mark_d_set();
        int lat, s0, m0;
        mem_lat = 1;
        mem_arr[12'h240] = {64'h0000_0000_0000_00CF, 64'h0000_0000_0000_0001};
        s0 = stores;
        do_mark(32'h2408, 1'b0, 1'b1, lat);
        m0 = mark_cnt;
        repeat (4) @(negedge clk);
        n_checks++;
        if (lat != 4 || mark_cnt != m0) begin
            n_fail++; $display("FAIL mark_d_set_latency: got %0d extra %0d, expected 4 0", lat, mark_cnt - m0);
        end
        n_checks++;
        if (stores != s0) begin
            n_fail++; $display("FAIL mark_d_set_nowrite: got %0d stores, expected 0", stores - s0);
        end
        mem_arr[12'h280] = {64'h0, 64'h0000_0000_0000_0000};
        s0 = stores;
        do_mark(32'h2800, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat != 4 || stores != s0) begin
            n_fail++; $display("FAIL mark_none: got lat %0d stores %0d, expected 4 0", lat, stores - s0);
        end
    endtask

    task automatic test_ack_first_cycle();
        int lat;
        mem_lat = 0;
        mem_arr[12'h120] = {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002};
        do_walk(32'h1200, lat);
        n_checks++;
        if (lat != 2) begin
            n_fail++; $display("FAIL ack_first_read_latency: got %0d, expected 2", lat);
        end
        mem_arr[12'h2C0] = {64'h0000_0000_0000_0055, 64'h0000_0000_0000_0000};
        do_mark(32'h2C00, 1'b0, 1'b1, lat);
        n_checks++;
        if (lat != 4 || mem_arr[12'h2C0] !== {64'h0000_0000_0000_0055, 64'h0000_0000_0000_00C0}) begin
            n_fail++; $display("FAIL ack_first_mark_d: got lat %0d line %h, expected 4 lo c0", lat, mem_arr[12'h2C0]);
        end
        mem_lat = 1;
    endtask

    task automatic test_collision();
        exp_t e;
        int w0, m0, rc, wseen, mseen;
        mem_lat = 1;
        mem_arr[12'h310] = {64'h0000_0000_0310_0001, 64'h0000_0000_0310_0000};
        mem_arr[12'h320] = {64'h0000_0000_0000_0000, 64'h0000_0000_0000_0003};
        e.line = mem_arr[12'h310];
        e.data = e.line[63:0];
        exp_q.push_back(e);
        w0 = walk_cnt;
        m0 = mark_cnt;
        @(negedge clk);
        walk_req_valid = 1'b1; walk_req_addr = 32'h3100;
        mark_valid = 1'b1; mark_addr = 64'h3200; mark_accessed = 1'b1; mark_dirty = 1'b0;
        rc = cyc;
        @(negedge clk);
        walk_req_valid = 1'b0; mark_valid = 1'b0;
        wseen = -1; mseen = -1;
        for (int i = 0; i < 60; i++) begin
            if (walk_cnt > w0 && wseen < 0) wseen = walk_cyc - rc;
            if (mark_cnt > m0 && mseen < 0) mseen = mark_cyc - rc;
            if (wseen >= 0 && mseen >= 0) break;
            @(negedge clk);
        end
        n_checks++;
        if (wseen < 0 || mseen < 0 || mseen <= wseen) begin
            n_fail++; $display("FAIL collision_order: got walk %0d mark %0d, expected walk before mark", wseen, mseen);
        end
        n_checks++;
        if (proto_err !== 1'b0 || mem_arr[12'h320] !== {64'h0, 64'h0000_0000_0000_0043}) begin
            n_fail++; $display("FAIL collision_mark: got proto_err %b line %h, expected 0 lo 43", proto_err, mem_arr[12'h320]);
        end

        mem_lat = 3;
        mem_arr[12'h330] = {64'h0000_0000_0330_0001, 64'h0000_0000_0330_0000};
        mem_arr[12'h340] = {64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        e.line = mem_arr[12'h330];
        e.data = e.line[127:64];
        exp_q.push_back(e);
        w0 = walk_cnt;
        m0 = mark_cnt;
        @(negedge clk);
        walk_req_valid = 1'b1; walk_req_addr = 32'h3308;
        mark_valid = 1'b1; mark_addr = 64'h3400; mark_accessed = 1'b1; mark_dirty = 1'b0;
        @(negedge clk);
        walk_req_valid = 1'b0; mark_valid = 1'b0;
        @(negedge clk);
        walk_req_valid = 1'b1; walk_req_addr = 32'h3500;
        @(negedge clk);
        walk_req_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (mark_cnt > m0) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++; $display("FAIL collision_proto_err: got %b, expected 1", proto_err);
        end
        n_checks++;
        if (walk_cnt - w0 != 1 || mark_cnt - m0 != 1 || mem_arr[12'h340] !== {64'h0, 64'h0000_0000_0000_0040}) begin
            n_fail++; $display("FAIL collision_extra_walk: got walks %0d marks %0d line %h, expected 1 1 lo 40",
                               walk_cnt - w0, mark_cnt - m0, mem_arr[12'h340]);
        end
        mem_lat = 1;
    endtask

    task automatic test_reset_mid();
        int s0, m0, lat, seen;
        mem_lat = 5;
        mem_arr[12'h400] = {64'h0, 64'h0000_0000_0000_0001};
        @(negedge clk);
        mark_valid = 1'b1; mark_addr = 64'h4000; mark_accessed = 1'b1; mark_dirty = 1'b0;
        @(negedge clk);
        mark_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (mem_valid && mem_store) begin seen = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (seen == 0 || mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_reach_write: got seen %0d valid %b, expected 1 1", seen, mem_valid);
        end
        s0 = stores;
        m0 = mark_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (mem_valid !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_drop: got valid %b proto_err %b, expected 0 0", mem_valid, proto_err);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (mark_cnt != m0 || stores != s0 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_quiet: got marks %0d stores %0d valid %b, expected 0 0 0",
                               mark_cnt - m0, stores - s0, mem_valid);
        end
        mem_lat = 1;
        mem_arr[12'h300] = {64'h0000_0000_3000_0001, 64'h0000_0000_3000_0000};
        do_walk(32'h3000, lat);
        n_checks++;
        if (lat != 3) begin
            n_fail++; $display("FAIL reset_mid_read_after: got %0d, expected 3", lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        mem_lat = 1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            mem_arr[12'h500 + i] = {$urandom, $urandom, $urandom, $urandom};
            a = 32'h5000 + 32'(i * 16) + ((i % 2 == 1) ? 32'h8 : 32'h0);
            do_walk(a, lat);
            n_checks++;
            if (lat != 3) begin
                n_fail++; $display("FAIL b2b_latency[%0d]: got %0d, expected 3", i, lat);
            end
        end
    endtask

`ifdef PTW_LINE_BUF_EN
    task automatic test_line_buf();
        int lat, a0, v0;
        mem_lat = 1;
        mem_arr[12'h600] = {64'h0000_0000_6000_0001, 64'h0000_0000_6000_0000};
        a0 = acks;
        do_walk(32'h6000, lat);
        n_checks++;
        if (lat != 3) begin
            n_fail++; $display("FAIL line_buf_miss_latency: got %0d, expected 3", lat);
        end
        v0 = mv_cycles;
        do_walk(32'h6008, lat);
        n_checks++;
        if (lat != 2 || acks - a0 != 1 || mv_cycles != v0) begin
            n_fail++; $display("FAIL line_buf_hit: got lat %0d acks %0d mv %0d, expected 2 1 0",
                               lat, acks - a0, mv_cycles - v0);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) mem_arr[i] = '0;
        test_reset();
        test_read();
        test_mark_a();
        test_mark_d_set();
        test_ack_first_cycle();
        test_collision();
        test_reset_mid();
        test_back_to_back();
`ifdef PTW_LINE_BUF_EN
        test_line_buf();
`endif
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL walk_rsp_missing: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
